usb_rx_packet_decoder: RTL and testbench

- Parametrised successor of the receive-side DP/DM decoder.
- Converts the raw DP/DM line pair (one line sample per clock) into decoded USB packets. Covers NRZI decode, bit-unstuffing, SYNC detection, full 8-bit PID validation with check nibble, and byte-wise payload delivery.
- Reports completion and error status at EOP.
- Sits between the bus line interface and the host-side transaction FSM.
- Replaces the fixed three-PID matcher with generic PID and payload handling.

---
 rtl/usb_rx_packet_decoder.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_usb_rx_packet_decoder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packet_decoder.sv
// Receive-side USB packet decoder: NRZI decode, unstuffing, SYNC/PID checks, byte delivery, EOP status.
// Optional CRC16 check on DATAx payloads is compiled in with `define USB_RX_CRC16_EN.
module usb_rx_packet_decoder #(
  parameter int unsigned MAX_BYTES    = 64,
  parameter int unsigned SYNC_TIMEOUT = 32,
  parameter int unsigned STUFF_LEN    = 6,
  localparam int unsigned CNT_W       = $clog2(MAX_BYTES + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             dp_in,
  input  logic             dm_in,
  input  logic             host_sending,
  output logic             rx_active,
  output logic [3:0]       pid_out,
  output logic             pid_valid,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic [CNT_W-1:0] byte_count,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic [2:0]       err_code
);

  localparam int unsigned TO_W   = $clog2(SYNC_TIMEOUT + 1);
  localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);

  localparam logic [2:0] ERR_PID     = 3'd1;
  localparam logic [2:0] ERR_STUFF   = 3'd2;
  localparam logic [2:0] ERR_OVF     = 3'd3;
  localparam logic [2:0] ERR_ALIGN   = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;
  localparam logic [2:0] ERR_CRC     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC_HUNT,
    S_PID,
    S_DATA,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic              prev_lvl_q, prev_lvl_d;
  logic              rx_active_q, rx_active_d;
  logic [3:0]        pid_out_q, pid_out_d;
  logic              pid_valid_q, pid_valid_d;
  logic [7:0]        byte_out_q, byte_out_d;
  logic              byte_valid_q, byte_valid_d;
  logic [CNT_W-1:0]  byte_count_q, byte_count_d;
  logic              pkt_done_q, pkt_done_d;
  logic              pkt_err_q, pkt_err_d;
  logic [2:0]        err_code_q, err_code_d;
  logic [7:0]        sr_q, sr_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic [2:0]        zeros_q, zeros_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic              se0_seen_q, se0_seen_d;

  logic       line_j_c, line_k_c, line_jk_c, line_se0_c, line_bit_c;
  logic       stuff_slot_c, bit_take_c, stuff_err_c;
  logic [7:0] shift_c;
  logic       crc_bad_c;

  // Line classification; SE1 falls into the SE0 bucket.
  assign line_j_c     = dp_in & ~dm_in;
  assign line_k_c     = ~dp_in & dm_in;
  assign line_jk_c    = line_j_c | line_k_c;
  assign line_se0_c   = ~line_jk_c;
  assign line_bit_c   = line_jk_c & (line_j_c == prev_lvl_q);
  assign stuff_slot_c = (ones_q == ONES_W'(STUFF_LEN));
  assign bit_take_c   = line_jk_c & ~stuff_slot_c;
  assign stuff_err_c  = line_jk_c & stuff_slot_c & line_bit_c;
  assign shift_c      = {line_bit_c, sr_q[7:1]};

`ifdef USB_RX_CRC16_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_chk_q, crc_chk_d;
  logic        crc_fb_c;
  logic [15:0] crc_next_c;

  assign crc_fb_c   = line_bit_c ^ crc_q[15];
  assign crc_next_c = {crc_q[14:0], 1'b0} ^ (crc_fb_c ? 16'h8005 : 16'h0000);
  assign crc_bad_c  = crc_chk_q & (crc_q != 16'h800D);
`else
  assign crc_bad_c  = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    prev_lvl_d   = line_jk_c ? line_j_c : prev_lvl_q;
    rx_active_d  = rx_active_q;
    pid_out_d    = pid_out_q;
    pid_valid_d  = 1'b0;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    byte_count_d = byte_count_q;
    pkt_done_d   = 1'b0;
    pkt_err_d    = 1'b0;
    err_code_d   = err_code_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    zeros_d      = zeros_q;
    tmo_d        = tmo_q;
    se0_seen_d   = se0_seen_q;
`ifdef USB_RX_CRC16_EN
    crc_d        = crc_q;
    crc_chk_d    = crc_chk_q;
`endif

    // Run-length of decoded ones for destuffing, tracked from the PID onward.
    if ((state_q == S_PID || state_q == S_DATA) && line_jk_c) begin
      if (stuff_slot_c || !line_bit_c) ones_d = '0;
      else                             ones_d = ONES_W'(ones_q + 1'b1);
    end

    case (state_q)
      S_IDLE: begin
        if (line_k_c) begin
          state_d      = S_SYNC_HUNT;
          rx_active_d  = 1'b1;
          tmo_d        = '0;
          zeros_d      = 3'd1;
          err_code_d   = '0;
          byte_count_d = '0;
          se0_seen_d   = 1'b0;
        end
      end

      S_SYNC_HUNT: begin
        if (line_se0_c) begin
          state_d     = S_IDLE;
          rx_active_d = 1'b0;
        end else if (line_bit_c && zeros_q == 3'd7) begin
          state_d   = S_PID;
          ones_d    = '0;
          bit_cnt_d = '0;
        end else if (tmo_q == TO_W'(SYNC_TIMEOUT - 1)) begin
          state_d     = S_IDLE;
          rx_active_d = 1'b0;
          err_code_d  = ERR_TIMEOUT;
          pkt_err_d   = 1'b1;
        end else begin
          tmo_d = TO_W'(tmo_q + 1'b1);
          if (line_bit_c)           zeros_d = '0;
          else if (zeros_q != 3'd7) zeros_d = 3'(zeros_q + 1'b1);
        end
      end

      S_PID: begin
        if (line_se0_c) begin
          state_d    = S_DRAIN;
          err_code_d = ERR_ALIGN;
          se0_seen_d = 1'b1;
        end else if (stuff_err_c) begin
          state_d    = S_DRAIN;
          err_code_d = ERR_STUFF;
          se0_seen_d = 1'b0;
        end else if (bit_take_c) begin
          sr_d      = shift_c;
          bit_cnt_d = 3'(bit_cnt_q + 1'b1);
          if (bit_cnt_q == 3'd7) begin
            if (shift_c[7:4] == ~shift_c[3:0]) begin
              state_d      = S_DATA;
              pid_out_d    = shift_c[3:0];
              pid_valid_d  = 1'b1;
              byte_count_d = '0;
              se0_seen_d   = 1'b0;
`ifdef USB_RX_CRC16_EN
              crc_d        = 16'hFFFF;
              crc_chk_d    = (shift_c[1:0] == 2'b11);
`endif
            end else begin
              state_d    = S_DRAIN;
              err_code_d = ERR_PID;
              se0_seen_d = 1'b0;
            end
          end
        end
      end

      S_DATA: begin
        if (se0_seen_q) begin
          // Waiting for the J that closes EOP; the verdict was fixed at SE0.
          if (line_j_c) begin
            state_d     = S_IDLE;
            rx_active_d = 1'b0;
            if (err_code_q == 3'd0) pkt_done_d = 1'b1;
            else                    pkt_err_d  = 1'b1;
          end
        end else if (line_se0_c) begin
          se0_seen_d = 1'b1;
          if (bit_cnt_q != 3'd0) err_code_d = ERR_ALIGN;
          else if (crc_bad_c)    err_code_d = ERR_CRC;
        end else if (stuff_err_c) begin
          state_d    = S_DRAIN;
          err_code_d = ERR_STUFF;
        end else if (bit_take_c) begin
          sr_d      = shift_c;
          bit_cnt_d = 3'(bit_cnt_q + 1'b1);
`ifdef USB_RX_CRC16_EN
          crc_d     = crc_next_c;
`endif
          if (bit_cnt_q == 3'd7) begin
            if (byte_count_q == CNT_W'(MAX_BYTES)) begin
              state_d    = S_DRAIN;
              err_code_d = ERR_OVF;
            end else begin
              byte_out_d   = shift_c;
              byte_valid_d = 1'b1;
              byte_count_d = CNT_W'(byte_count_q + 1'b1);
            end
          end
        end
      end

      S_DRAIN: begin
        if (line_se0_c) begin
          se0_seen_d = 1'b1;
        end else if (line_j_c && se0_seen_q) begin
          state_d     = S_IDLE;
          rx_active_d = 1'b0;
          pkt_err_d   = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        rx_active_d = 1'b0;
      end
    endcase

    // Host owns the bus: abandon the packet quietly.
    if (host_sending) begin
      state_d      = S_IDLE;
      rx_active_d  = 1'b0;
      byte_count_d = '0;
      bit_cnt_d    = '0;
      ones_d       = '0;
      zeros_d      = '0;
      tmo_d        = '0;
      se0_seen_d   = 1'b0;
      pid_valid_d  = 1'b0;
      byte_valid_d = 1'b0;
      pkt_done_d   = 1'b0;
      pkt_err_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      prev_lvl_q   <= 1'b1;
      rx_active_q  <= 1'b0;
      pid_out_q    <= '0;
      pid_valid_q  <= 1'b0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_count_q <= '0;
      pkt_done_q   <= 1'b0;
      pkt_err_q    <= 1'b0;
      err_code_q   <= '0;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      ones_q       <= '0;
      zeros_q      <= '0;
      tmo_q        <= '0;
      se0_seen_q   <= 1'b0;
`ifdef USB_RX_CRC16_EN
      crc_q        <= '0;
      crc_chk_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      prev_lvl_q   <= prev_lvl_d;
      rx_active_q  <= rx_active_d;
      pid_out_q    <= pid_out_d;
      pid_valid_q  <= pid_valid_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_count_q <= byte_count_d;
      pkt_done_q   <= pkt_done_d;
      pkt_err_q    <= pkt_err_d;
      err_code_q   <= err_code_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_q       <= ones_d;
      zeros_q      <= zeros_d;
      tmo_q        <= tmo_d;
      se0_seen_q   <= se0_seen_d;
`ifdef USB_RX_CRC16_EN
      crc_q        <= crc_d;
      crc_chk_q    <= crc_chk_d;
`endif
    end
  end

  assign rx_active  = rx_active_q;
  assign pid_out    = pid_out_q;
  assign pid_valid  = pid_valid_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign byte_count = byte_count_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_err    = pkt_err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// Directed bench for usb_rx_packet_decoder: NRZI/stuffing encoder drives the line, pulses are logged at negedge.
module tb_usb_rx_packet_decoder;

  logic clock = 1'b0;
  logic reset_n, dp_in, dm_in, host_sending;

  logic       rx_active, pid_valid, byte_valid, pkt_done, pkt_err;
  logic [3:0] pid_out;
  logic [7:0] byte_out;
  logic [6:0] byte_count;
  logic [2:0] err_code;

  logic       rx_active_b, pid_valid_b, byte_valid_b, pkt_done_b, pkt_err_b;
  logic [3:0] pid_out_b;
  logic [7:0] byte_out_b;
  logic [2:0] byte_count_b;
  logic [2:0] err_code_b;

  usb_rx_packet_decoder dut (
    .clock(clock), .reset_n(reset_n), .dp_in(dp_in), .dm_in(dm_in),
    .host_sending(host_sending), .rx_active(rx_active), .pid_out(pid_out),
    .pid_valid(pid_valid), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_count(byte_count), .pkt_done(pkt_done), .pkt_err(pkt_err),
    .err_code(err_code)
  );

  usb_rx_packet_decoder #(.MAX_BYTES(4)) dut_small (
    .clock(clock), .reset_n(reset_n), .dp_in(dp_in), .dm_in(dm_in),
    .host_sending(host_sending), .rx_active(rx_active_b), .pid_out(pid_out_b),
    .pid_valid(pid_valid_b), .byte_out(byte_out_b), .byte_valid(byte_valid_b),
    .byte_count(byte_count_b), .pkt_done(pkt_done_b), .pkt_err(pkt_err_b),
    .err_code(err_code_b)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_pid, n_done, n_err, n_bad, nb_err, nb_bytes;
  logic [2:0] err_at, eb_at;
  logic [7:0] rx_bytes[$];

  logic       lvl;
  int         ones;
  bit         stuff_on;
  logic [7:0] pkt [3];
  logic [15:0] crc;

  // Pulse logger, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      if (byte_valid) rx_bytes.push_back(byte_out);
      if (pid_valid)  n_pid++;
      if (pkt_done)   n_done++;
      if (pkt_err) begin n_err++; err_at = err_code; end
      if ((pkt_done && pkt_err) || (byte_valid && pkt_done)) n_bad++;
      if (byte_valid_b) nb_bytes++;
      if (pkt_err_b) begin nb_err++; eb_at = err_code_b; end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_pid = 0; n_done = 0; n_err = 0; nb_err = 0; nb_bytes = 0;
    err_at = '0; eb_at = '0;
    rx_bytes.delete();
  endtask

  task automatic drive_line(input logic dp, input logic dm);
    @(negedge clock);
    dp_in = dp;
    dm_in = dm;
    @(posedge clock);
    #1;
  endtask

  task automatic nrzi_bit(input logic b);
    if (!b) lvl = ~lvl;
    drive_line(lvl, ~lvl);
  endtask

  task automatic tx_bit(input logic b);
    nrzi_bit(b);
    if (stuff_on) begin
      if (b) begin
        ones++;
        if (ones == 6) begin
          nrzi_bit(1'b0);
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
  endtask

  task automatic tx_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) tx_bit(v[i]);
  endtask

  task automatic tx_sync();
    stuff_on = 1'b0;
    for (int i = 0; i < 7; i++) nrzi_bit(1'b0);
    nrzi_bit(1'b1);
    ones = 0;
    stuff_on = 1'b1;
  endtask

  task automatic tx_eop();
    drive_line(1'b0, 1'b0);
    drive_line(1'b0, 1'b0);
    lvl = 1'b1;
    drive_line(1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    lvl = 1'b1;
    for (int i = 0; i < n; i++) drive_line(1'b1, 1'b0);
  endtask

  // Reflected CRC-16/USB over three bytes; returns the complemented value sent low byte first.
  function automatic logic [15:0] usb_crc16(input logic [7:0] d [3]);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      c = c ^ {8'h00, d[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  initial begin
    reset_n = 1'b0; dp_in = 1'b1; dm_in = 1'b0; host_sending = 1'b0;
    lvl = 1'b1; ones = 0; stuff_on = 1'b0; n_bad = 0;
    clear_counts();
    repeat (3) @(posedge clock);
    #1;
    check("reset_rx_active", rx_active, 0);
    check("reset_pid_out", pid_out, 0);
    check("reset_err_code", err_code, 0);
    check("reset_byte_count", byte_count, 0);
    check("reset_pulses", {pid_valid, byte_valid, pkt_done, pkt_err}, 0);
    @(negedge clock) reset_n = 1'b1;
    idle(3);

    // ACK handshake
    clear_counts();
    tx_sync();
    tx_byte(8'hD2);
    check("ack_pid_valid", pid_valid, 1);
    check("ack_pid_out", pid_out, 4'h2);
    check("ack_rx_active", rx_active, 1);
    tx_eop();
    check("ack_pkt_done", pkt_done, 1);
    check("ack_pkt_err", pkt_err, 0);
    check("ack_rx_active_drop", rx_active, 0);
    check("ack_byte_count", byte_count, 0);
    check("ack_err_code", err_code, 0);
    idle(2);
    check("ack_done_once", n_done, 1);

    // DATA0 with valid CRC
    clear_counts();
    pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03;
    crc = usb_crc16(pkt);
    tx_sync();
    tx_byte(8'hC3);
    for (int i = 0; i < 3; i++) tx_byte(pkt[i]);
    tx_byte(crc[7:0]);
    tx_byte(crc[15:8]);
    tx_eop();
    idle(2);
    check("d0_byte_pulses", rx_bytes.size(), 5);
    if (rx_bytes.size() == 5) begin
      for (int i = 0; i < 3; i++) check("d0_payload", rx_bytes[i], pkt[i]);
      check("d0_crc_lo", rx_bytes[3], crc[7:0]);
      check("d0_crc_hi", rx_bytes[4], crc[15:8]);
    end
    check("d0_byte_count", byte_count, 5);
    check("d0_done", n_done, 1);
    check("d0_err", n_err, 0);

    // DATA0 with zeroed CRC
    clear_counts();
    tx_sync();
    tx_byte(8'hC3);
    for (int i = 0; i < 3; i++) tx_byte(pkt[i]);
    tx_byte(8'h00);
    tx_byte(8'h00);
    tx_eop();
    idle(2);
    check("badcrc_bytes", rx_bytes.size(), 5);
`ifdef USB_RX_CRC16_EN
    check("badcrc_err", n_err, 1);
    check("badcrc_done", n_done, 0);
    check("badcrc_code", err_at, 6);
`else
    check("badcrc_err", n_err, 0);
    check("badcrc_done", n_done, 1);
    check("badcrc_code", err_code, 0);
`endif

    // Stuffed 0xFF payload
    clear_counts();
    tx_sync();
    tx_byte(8'h5A);
    tx_byte(8'hFF);
    tx_eop();
    idle(2);
    check("stuff_bytes", rx_bytes.size(), 1);
    if (rx_bytes.size() == 1) check("stuff_value", rx_bytes[0], 8'hFF);
    check("stuff_done", n_done, 1);
    check("stuff_pid", pid_out, 4'hA);

    // Stuff violation: seven ones in a row
    clear_counts();
    tx_sync();
    tx_byte(8'h5A);
    stuff_on = 1'b0;
    for (int i = 0; i < 8; i++) nrzi_bit(1'b1);
    tx_eop();
    idle(2);
    check("stufferr_err", n_err, 1);
    check("stufferr_code", err_at, 2);
    check("stufferr_bytes", rx_bytes.size(), 0);
    check("stufferr_done", n_done, 0);

    // Bad PID check nibble
    clear_counts();
    tx_sync();
    tx_byte(8'hD3);
    tx_eop();
    idle(2);
    check("badpid_valid", n_pid, 0);
    check("badpid_err", n_err, 1);
    check("badpid_code", err_at, 1);

    // Overflow on the MAX_BYTES=4 instance
    clear_counts();
    tx_sync();
    tx_byte(8'h4B);
    for (int i = 1; i <= 5; i++) tx_byte(8'(i * 17));
    tx_eop();
    idle(2);
    check("ovf_bytes", nb_bytes, 4);
    check("ovf_err", nb_err, 1);
    check("ovf_code", eb_at, 3);
    check("ovf_byte_count", byte_count_b, 4);

    // Alignment: 12 payload bits
    clear_counts();
    tx_sync();
    tx_byte(8'h5A);
    tx_byte(8'h11);
    tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b1); tx_bit(1'b0);
    tx_eop();
    idle(2);
    check("align_bytes", rx_bytes.size(), 1);
    check("align_err", n_err, 1);
    check("align_code", err_at, 4);
    check("align_done", n_done, 0);

    // SYNC timeout: alternating K/J never produces the closing 1
    clear_counts();
    for (int i = 1; i <= 33; i++) begin
      if (i % 2 == 1) drive_line(1'b0, 1'b1);
      else            drive_line(1'b1, 1'b0);
      if (i == 32) check("tmo_not_early", pkt_err, 0);
    end
    check("tmo_pulse", pkt_err, 1);
    check("tmo_code", err_code, 5);
    check("tmo_rx_active", rx_active, 0);
    idle(3);
    check("tmo_err_once", n_err, 1);

    // Host takes the bus mid-DATA
    clear_counts();
    tx_sync();
    tx_byte(8'hC3);
    tx_byte(8'hAA);
    check("host_pre_count", byte_count, 1);
    host_sending = 1'b1;
    drive_line(lvl, ~lvl);
    check("host_rx_active", rx_active, 0);
    check("host_byte_count", byte_count, 0);
    idle(3);
    tx_eop();
    idle(2);
    host_sending = 1'b0;
    idle(3);
    check("host_no_done", n_done, 0);
    check("host_no_err", n_err, 0);

    // Reset mid-packet
    clear_counts();
    tx_sync();
    tx_byte(8'hC3);
    check("rst_pid_valid", pid_valid, 1);
    tx_byte(8'h55);
    reset_n = 1'b0;
    #2;
    check("rst_rx_active", rx_active, 0);
    check("rst_pid_out", pid_out, 0);
    check("rst_byte_count", byte_count, 0);
    @(negedge clock) reset_n = 1'b1;
    idle(3);

    check("no_overlap_pulses", n_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
